acc_share_arbiter: RTL and testbench
====================================

Name: acc_share_arbiter

Overview:
Shares one accelerator slot, i.e. one consumer/producer valid-ready stream pair, between NUM_REQ requesters, such as FIFO controllers on one tile.
- Grants one requester at a time, round-robin.
- Forwards exactly s_ratio input beats from that requester into the accelerator.
- Returns exactly d_ratio output beats to the same requester.
- Then releases the slot.
- Sits between the FIFO controllers and the acc wrapper; replaces a fixed one-to-one binding.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 64, data beat width, matching fifo_ctrl_pkg data_t.
- CNT_W, 16, width of the beat counters and ratios.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous reset, active low.
- serialization_ratio, in, CNT_W, input beats per transaction; sampled at grant.
- deserialization_ratio, in, CNT_W, output beats per transaction; sampled at grant.
- req_in_valid, in, NUM_REQ, per-requester input beat valid.
- req_in_ready, out, NUM_REQ, per-requester input beat ready.
- req_in_data, in, NUM_REQ x DATA_W, per-requester input data.
- req_out_valid, out, NUM_REQ, per-requester result valid.
- req_out_ready, in, NUM_REQ, per-requester result ready.
- req_out_data, out, DATA_W, result data, broadcast to all requesters.
- acc_in_valid, out, 1, to accelerator consumer port.
- acc_in_ready, in, 1, from accelerator consumer port.
- acc_in_data, out, DATA_W, to accelerator consumer port.
- acc_out_valid, in, 1, from accelerator producer port.
- acc_out_ready, out, 1, to accelerator producer port.
- acc_out_data, in, DATA_W, from accelerator producer port.
- grant_id, out, $clog2(NUM_REQ), current or last granted requester.
- busy, out, 1, high in S_FEED or S_DRAIN.

Behaviour:
- Reset values:
  - state = S_IDLE; rr_ptr = 0; grant_id = 0; counters = 0; latched ratios = 0.
  - All valid/ready outputs 0; busy = 0.
- States: S_IDLE, S_FEED, S_DRAIN (2-bit enum).
- S_IDLE:
  - Arbitration takes exactly one cycle; no beats transfer in this state.
  - Winner is the first requester with req_in_valid=1, searching from rr_ptr upward with wrap-around.
  - On a win, register:
    - grant_id = winner;
    - rr_ptr = (winner+1) mod NUM_REQ;
    - s_ratio_q, d_ratio_q = ratio inputs;
    - s_cnt = d_cnt = 0.
  - Next state: S_FEED if s_ratio_q != 0, else S_DRAIN if d_ratio_q != 0, else S_IDLE. A grant with both ratios 0 is a no-op, but rr_ptr still advances.
  - No requester valid: stay in S_IDLE, rr_ptr unchanged.
- S_FEED (zero-latency combinational pass-through):
  - acc_in_valid = req_in_valid[grant_id]; acc_in_data = req_in_data[grant_id].
  - req_in_ready[grant_id] = acc_in_ready; all other req_in_ready = 0.
  - acc_out_ready = 0.
  - On each fire (acc_in_valid & acc_in_ready): s_cnt++.
  - Fire with s_cnt+1 == s_ratio_q: next state is S_DRAIN if d_ratio_q != 0, else S_IDLE.
- S_DRAIN:
  - req_out_valid[grant_id] = acc_out_valid; req_out_data = acc_out_data.
  - acc_out_ready = req_out_ready[grant_id]; all other req_out_valid = 0.
  - req_in_ready all 0; acc_in_valid = 0.
  - On each fire: d_cnt++.
  - Fire with d_cnt+1 == d_ratio_q: next state S_IDLE.
- Ratio changes mid-transaction have no effect; only the latched values count.
- Non-granted requesters are never ready and never see valid.
  - Invariant: at most one bit of req_in_ready and at most one bit of req_out_valid set per cycle.
- acc_out_valid outside S_DRAIN is ignored (ready held 0). No data is dropped.
- Back-to-back: the earliest next grant is the cycle after the last S_DRAIN beat, so there is one idle bubble cycle.
- Reset mid-transaction: returns to S_IDLE next edge. Partial beats are abandoned; the accelerator is reset by the same rst_n.
- Counters compare for equality. A ratio of 2^CNT_W-1 is legal; no wrap occurs within a transaction.

Optional Feature:
ACC_SHARE_ARBITER_TIMEOUT_EN:
- Defined:
  - Adds a cycle counter, cleared on every S_FEED/S_DRAIN fire and on state entry.
  - If it reaches TIMEOUT_CYCLES while in S_FEED or S_DRAIN, the block returns to S_IDLE.
  - Adds output port timeout_err, a 1-cycle pulse with grant_id held, and a sticky output timeout_sticky, cleared only by reset.
- Undefined: neither port nor the counter exists; the block waits indefinitely.

Decomposition:
- Shared package acc_arb_pkg holds:
  - state typedef arb_state_t;
  - default DATA_W/CNT_W constants;
  - function rr_pick(valid vector, rr_ptr) returning winner index plus a found bit.
- One natural sub-module: acc_rr_arbiter (NUM_REQ), a combinational round-robin picker with a registered pointer update on grant strobe.

Test Plan:
- NUM_REQ=4, req 2 valid only, ratios s=4, d=2 → grant_id=2; 4 acc_in beats carry req 2's data; 2 results reach only req_out_valid[2]; busy drops after the 2nd result.
- Reqs 0,1,3 all continuously valid, ratios 1/1 → grant order 0,1,3,0; one idle cycle between transactions.
- acc_in_ready toggling 1,0,0,1 during FEED with s=3 → s_cnt increments only on fires; exits FEED only after the 3rd fire.
- s=0, d=3 → IDLE goes directly to DRAIN; 3 results delivered. s=0, d=0 → no beats; rr_ptr still advances.
- rst_n low for 1 cycle mid-DRAIN (d_cnt=1 of 3) → all outputs 0 next cycle, state S_IDLE, rr_ptr=0.
- With ACC_SHARE_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, acc_out_valid stuck 0 in DRAIN → timeout_err pulses once on the 8th cycle; return to S_IDLE; timeout_sticky=1.

Source files
------------

// File: rtl/acc_arb_pkg.sv
// Shared types and helpers for the accelerator-slot sharing arbiter.
// State encoding, default widths and the round-robin pick function live here.
package acc_arb_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_CNT_W  = 16;
   localparam int MAX_REQ    = 16;
   localparam int REQ_IDX_W  = 4;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t S_IDLE  = 2'd0;
   localparam arb_state_t S_FEED  = 2'd1;
   localparam arb_state_t S_DRAIN = 2'd2;

   typedef struct packed {
      logic                 found;
      logic [REQ_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit at or after ptr, wrapping at num_req. Scanning offsets from the
   // far end down means the smallest offset is the last (and winning) assignment.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                        input logic [REQ_IDX_W-1:0] ptr,
                                        input int num_req);
      rr_pick_t r;
      int       cand;
      r = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < num_req) begin
            cand = (int'(ptr) + i) % num_req;
            if (valid[cand]) begin
               r.found = 1'b1;
               r.idx   = cand[REQ_IDX_W-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/acc_rr_arbiter.sv
// Combinational round-robin picker; the search pointer moves past the winner
// only on the cycle the grant is actually taken.
module acc_rr_arbiter
   import acc_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               grant_strobe,
   output logic               found,
   output logic [IDX_W-1:0]   winner,
   output logic [IDX_W-1:0]   rr_ptr
);

   logic [MAX_REQ-1:0] valid_ext;
   rr_pick_t           pick;
   logic               unused_idx_bits;

   always_comb begin
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = req_valid;
      pick                     = rr_pick(valid_ext, REQ_IDX_W'(rr_ptr), NUM_REQ);
   end

   assign found           = pick.found;
   assign winner          = pick.idx[IDX_W-1:0];
   assign unused_idx_bits = ^pick.idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (grant_strobe) begin
         rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
      end
   end

endmodule

// File: rtl/acc_share_arbiter.sv
// Shares one accelerator stream pair among NUM_REQ requesters, one transaction at a time.
// Optional watchdog: define ACC_SHARE_ARBITER_TIMEOUT_EN to add timeout_err/timeout_sticky.
//
// Handshake: a beat transfers on any edge where valid and ready are both high;
// valid never depends on ready, and ready/valid of the granted requester are
// plain combinational pass-throughs of the accelerator side.
module acc_share_arbiter
   import acc_arb_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int DATA_W         = DEF_DATA_W,
   parameter  int CNT_W          = DEF_CNT_W,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int IDX_W          = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CNT_W-1:0]          serialization_ratio,
   input  logic [CNT_W-1:0]          deserialization_ratio,
   input  logic [NUM_REQ-1:0]        req_in_valid,
   output logic [NUM_REQ-1:0]        req_in_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_in_data,
   output logic [NUM_REQ-1:0]        req_out_valid,
   input  logic [NUM_REQ-1:0]        req_out_ready,
   output logic [DATA_W-1:0]         req_out_data,
   output logic                      acc_in_valid,
   input  logic                      acc_in_ready,
   output logic [DATA_W-1:0]         acc_in_data,
   input  logic                      acc_out_valid,
   output logic                      acc_out_ready,
   input  logic [DATA_W-1:0]         acc_out_data,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy,
`ifdef ACC_SHARE_ARBITER_TIMEOUT_EN
   output logic                      timeout_err,
   output logic                      timeout_sticky,
`endif
   output logic [1:0]                state_dbg
);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("acc_share_arbiter: parameter out of range");
   end

   arb_state_t         state, state_nx;
   logic [IDX_W-1:0]   grant_q;
   logic [CNT_W-1:0]   s_cnt, d_cnt, s_ratio_q, d_ratio_q;
   logic               found;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   rr_ptr;
   logic               grant_strobe;
   logic               in_fire, out_fire;
   logic [DATA_W-1:0]  in_data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign in_data_arr[g] = req_in_data[g*DATA_W +: DATA_W];
   end

   assign grant_strobe = (state == S_IDLE) && found;

   acc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_in_valid),
      .grant_strobe (grant_strobe),
      .found        (found),
      .winner       (winner),
      .rr_ptr       (rr_ptr)
   );

   always_comb begin
      req_in_ready  = '0;
      req_out_valid = '0;
      acc_in_valid  = 1'b0;
      acc_out_ready = 1'b0;
      if (state == S_FEED) begin
         acc_in_valid          = req_in_valid[grant_q];
         req_in_ready[grant_q] = acc_in_ready;
      end
      if (state == S_DRAIN) begin
         req_out_valid[grant_q] = acc_out_valid;
         acc_out_ready          = req_out_ready[grant_q];
      end
   end

   assign acc_in_data  = in_data_arr[grant_q];
   assign req_out_data = acc_out_data;
   assign in_fire      = acc_in_valid & acc_in_ready;
   assign out_fire     = acc_out_valid & acc_out_ready;
   assign grant_id     = grant_q;
   assign busy         = (state == S_FEED) || (state == S_DRAIN);
   assign state_dbg    = state;

`ifdef ACC_SHARE_ARBITER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_expire;

   // Expires on the TIMEOUT_CYCLES-th consecutive cycle without progress.
   assign wd_expire   = busy && !(in_fire || out_fire) &&
                        (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = wd_expire;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (found) begin
               if (serialization_ratio != '0)        state_nx = S_FEED;
               else if (deserialization_ratio != '0) state_nx = S_DRAIN;
               else                                  state_nx = S_IDLE;
            end
         end
         S_FEED: begin
            if (in_fire && (s_cnt + CNT_W'(1) == s_ratio_q))
               state_nx = (d_ratio_q != '0) ? S_DRAIN : S_IDLE;
         end
         S_DRAIN: begin
            if (out_fire && (d_cnt + CNT_W'(1) == d_ratio_q))
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
`ifdef ACC_SHARE_ARBITER_TIMEOUT_EN
      if (wd_expire) state_nx = S_IDLE;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         grant_q   <= '0;
         s_cnt     <= '0;
         d_cnt     <= '0;
         s_ratio_q <= '0;
         d_ratio_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant_q   <= winner;
                  s_ratio_q <= serialization_ratio;
                  d_ratio_q <= deserialization_ratio;
                  s_cnt     <= '0;
                  d_cnt     <= '0;
               end
            end
            S_FEED:  if (in_fire)  s_cnt <= s_cnt + CNT_W'(1);
            S_DRAIN: if (out_fire) d_cnt <= d_cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

`ifdef ACC_SHARE_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt         <= '0;
         timeout_sticky <= 1'b0;
      end else begin
         if (!busy || in_fire || out_fire || (state_nx != state))
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_expire) timeout_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_acc_share_arbiter.sv
// Self-checking bench for acc_share_arbiter (default build, NUM_REQ=4):
// directed vector table, multi-cycle corner sequences, and a random run against a transaction model.
module tb_acc_share_arbiter;
   import acc_arb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CW-1:0]   serialization_ratio, deserialization_ratio;
   logic [N-1:0]    req_in_valid, req_in_ready, req_out_valid, req_out_ready;
   logic [N*DW-1:0] req_in_data;
   logic [DW-1:0]   req_out_data, acc_in_data, acc_out_data;
   logic            acc_in_valid, acc_in_ready, acc_out_valid, acc_out_ready;
   logic [1:0]      grant_id;
   logic            busy;
   logic [1:0]      state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] exp_q[$];

   acc_share_arbiter #(
      .NUM_REQ(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .serialization_ratio   (serialization_ratio),
      .deserialization_ratio (deserialization_ratio),
      .req_in_valid          (req_in_valid),
      .req_in_ready          (req_in_ready),
      .req_in_data           (req_in_data),
      .req_out_valid         (req_out_valid),
      .req_out_ready         (req_out_ready),
      .req_out_data          (req_out_data),
      .acc_in_valid          (acc_in_valid),
      .acc_in_ready          (acc_in_ready),
      .acc_in_data           (acc_in_data),
      .acc_out_valid         (acc_out_valid),
      .acc_out_ready         (acc_out_ready),
      .acc_out_data          (acc_out_data),
      .grant_id              (grant_id),
      .busy                  (busy),
      .state_dbg             (state_dbg)
   );

   // clock/reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic zero_inputs();
      serialization_ratio   = '0;
      deserialization_ratio = '0;
      req_in_valid          = '0;
      req_out_ready         = '0;
      acc_in_ready          = 1'b0;
      acc_out_valid         = 1'b0;
      acc_out_data          = '0;
   endtask

   task automatic set_req_data();
      for (int i = 0; i < N; i++)
         req_in_data[i*DW +: DW] = {8'hD0, 8'(i), 16'h0, $urandom()};
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      zero_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0]  mask;
      logic [CW-1:0] s;
      logic [CW-1:0] d;
      logic [1:0]    exp_grant;
      logic          exp_busy;
   } vec_t;

   vec_t vecs[9];

   // model state for random run
   int m_active, m_owner, m_ptr, m_s_left, m_d_left;

   initial begin
      int fi, fo, fires;
      logic [4:0] tog;
      logic [1:0] order [4];
      logic [N-1:0]  e_in_ready, e_out_valid;
      logic          e_acc_in_valid, e_acc_out_ready;
      logic [DW-1:0] popped;

      rst_n = 1'b0;
      set_req_data();
      zero_inputs();

      // reset state, with inputs active to show they are ignored while idle
      req_in_valid  = '1;
      acc_in_ready  = 1'b1;
      acc_out_valid = 1'b1;
      req_out_ready = '1;
      serialization_ratio = 16'd2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", state_dbg, S_IDLE);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_in_ready", req_in_ready, 0);
      chk("rst_out_valid", req_out_valid, 0);
      chk("rst_acc_in_valid", acc_in_valid, 0);
      chk("rst_acc_out_ready", acc_out_ready, 0);

      // round-robin among 0,1,3 with 1/1 ratios: busy pattern 0,1,1 repeating
      do_reset();
      req_in_valid = 4'b1011;
      serialization_ratio = 16'd1; deserialization_ratio = 16'd1;
      acc_in_ready = 1'b1; acc_out_valid = 1'b1; req_out_ready = '1;
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("rr_busy_%0d", k), busy, ((k % 3) != 0));
         if ((k % 3) == 1) chk($sformatf("rr_grant_%0d", k), grant_id, order[k/3]);
         @(posedge clk); #1;
      end

      // vector table: grant and beat counts per transaction
      vecs[0] = '{4'b0100, 16'd4, 16'd2, 2'd2, 1'b1};
      vecs[1] = '{4'b1011, 16'd1, 16'd1, 2'd3, 1'b1};
      vecs[2] = '{4'b1011, 16'd1, 16'd1, 2'd0, 1'b1};
      vecs[3] = '{4'b1011, 16'd1, 16'd1, 2'd1, 1'b1};
      vecs[4] = '{4'b1011, 16'd2, 16'd1, 2'd3, 1'b1};
      vecs[5] = '{4'b1111, 16'd0, 16'd3, 2'd0, 1'b1};
      vecs[6] = '{4'b1111, 16'd0, 16'd0, 2'd1, 1'b0};
      vecs[7] = '{4'b0011, 16'd2, 16'd0, 2'd0, 1'b1};
      vecs[8] = '{4'b0011, 16'd1, 16'd1, 2'd1, 1'b1};
      do_reset();
      for (int v = 0; v < 9; v++) begin
         set_req_data();
         req_in_valid = vecs[v].mask;
         serialization_ratio = vecs[v].s; deserialization_ratio = vecs[v].d;
         acc_in_ready = 1'b1; acc_out_valid = 1'b1; req_out_ready = '1;
         acc_out_data = {$urandom(), $urandom()};
         @(posedge clk); #1;
         chk($sformatf("vec%0d_grant", v), grant_id, vecs[v].exp_grant);
         chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
         fi = 0; fo = 0;
         for (int c = 0; c < 64 && busy; c++) begin
            @(negedge clk);
            if (acc_in_valid && acc_in_ready) begin
               fi++;
               chk($sformatf("vec%0d_in_data", v), acc_in_data,
                   req_in_data[vecs[v].exp_grant*DW +: DW]);
            end
            if (acc_out_valid && acc_out_ready) begin
               fo++;
               chk($sformatf("vec%0d_out_valid", v), req_out_valid, 4'b0001 << vecs[v].exp_grant);
            end
            @(posedge clk); #1;
         end
         chk($sformatf("vec%0d_done", v), busy, 0);
         chk($sformatf("vec%0d_in_beats", v), fi, vecs[v].s);
         chk($sformatf("vec%0d_out_beats", v), fo, vecs[v].d);
      end

      // FEED with stalling accelerator: leaves FEED only after the 3rd fire
      do_reset();
      req_in_valid = 4'b0001;
      serialization_ratio = 16'd3; deserialization_ratio = 16'd1;
      @(posedge clk); #1;
      chk("stall_enter_feed", state_dbg, S_FEED);
      tog = 5'b11001;
      fires = 0;
      for (int i = 0; i < 5; i++) begin
         acc_in_ready = tog[i];
         @(negedge clk);
         chk($sformatf("stall_in_valid_%0d", i), acc_in_valid, 1);
         chk($sformatf("stall_in_ready_%0d", i), req_in_ready, {3'b000, tog[i]});
         if (tog[i]) fires++;
         @(posedge clk); #1;
         chk($sformatf("stall_state_%0d", i), state_dbg, (fires < 3) ? S_FEED : S_DRAIN);
      end

      // reset in the middle of DRAIN
      do_reset();
      req_in_valid = 4'b0100;
      serialization_ratio = 16'd0; deserialization_ratio = 16'd3;
      acc_out_valid = 1'b1; req_out_ready = 4'b0100;
      @(posedge clk); #1;
      chk("mid_rst_drain", state_dbg, S_DRAIN);
      chk("mid_rst_grant2", grant_id, 2);
      req_in_valid = '0;
      @(posedge clk); #1;
      chk("mid_rst_still_drain", state_dbg, S_DRAIN);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_state", state_dbg, S_IDLE);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant_id, 0);
      chk("mid_rst_out_valid", req_out_valid, 0);
      chk("mid_rst_acc_out_ready", acc_out_ready, 0);
      req_in_valid = 4'b1111;
      serialization_ratio = 16'd1; deserialization_ratio = 16'd0;
      @(posedge clk); #1;
      chk("mid_rst_ptr_zero", grant_id, 0);

      // random traffic against a transaction-level model
      do_reset();
      m_active = 0; m_owner = 0; m_ptr = 0; m_s_left = 0; m_d_left = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) req_in_valid[i] = ($urandom_range(0, 9) < 6);
         set_req_data();
         serialization_ratio   = CW'($urandom_range(0, 3));
         deserialization_ratio = CW'($urandom_range(0, 3));
         acc_in_ready  = ($urandom_range(0, 3) != 0);
         acc_out_valid = ($urandom_range(0, 1) == 1);
         acc_out_data  = {$urandom(), $urandom()};
         req_out_ready = N'($urandom_range(0, 15));
         @(negedge clk);

         e_in_ready = '0; e_out_valid = '0; e_acc_in_valid = 1'b0; e_acc_out_ready = 1'b0;
         if (m_active != 0 && m_s_left > 0) begin
            e_acc_in_valid = req_in_valid[m_owner];
            e_in_ready[m_owner] = acc_in_ready;
         end else if (m_active != 0) begin
            e_out_valid[m_owner] = acc_out_valid;
            e_acc_out_ready = req_out_ready[m_owner];
         end
         chk("rnd_busy", busy, m_active);
         chk("rnd_grant", grant_id, m_owner);
         chk("rnd_in_ready", req_in_ready, e_in_ready);
         chk("rnd_acc_in_valid", acc_in_valid, e_acc_in_valid);
         chk("rnd_out_valid", req_out_valid, e_out_valid);
         chk("rnd_acc_out_ready", acc_out_ready, e_acc_out_ready);
         if (acc_out_valid && e_acc_out_ready) chk("rnd_out_data", req_out_data, acc_out_data);

         // model step
         if (m_active == 0) begin
            for (int o = N - 1; o >= 0; o--)
               if (req_in_valid[(m_ptr + o) % N]) m_owner = (m_ptr + o) % N;
            if (req_in_valid != '0) begin
               m_ptr    = (m_owner + 1) % N;
               m_s_left = int'(serialization_ratio);
               m_d_left = int'(deserialization_ratio);
               m_active = (m_s_left + m_d_left) > 0 ? 1 : 0;
            end
         end else if (m_s_left > 0) begin
            if (req_in_valid[m_owner] && acc_in_ready) begin
               exp_q.push_back(req_in_data[m_owner*DW +: DW]);
               m_s_left--;
               if (m_s_left == 0 && m_d_left == 0) m_active = 0;
            end
         end else begin
            if (acc_out_valid && req_out_ready[m_owner]) begin
               m_d_left--;
               if (m_d_left == 0) m_active = 0;
            end
         end

         // scoreboard for accelerator input beats
         if (acc_in_valid && acc_in_ready) begin
            if (exp_q.size() == 0) begin
               chk("rnd_in_beat_unexpected", 1, 0);
            end else begin
               popped = exp_q.pop_front();
               chk("rnd_in_beat_data", acc_in_data, popped);
            end
         end
         @(posedge clk); #1;
      end
      chk("rnd_in_beats_left", exp_q.size(), 0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
